// File: rtl/pc_gen_pkg.sv
// pc_gen shared definitions: default widths, reset PC,
// the NOP pushed for a misaligned redirect, and the fetch mode.
package pc_gen_pkg;

    localparam int          DEF_WORD   = 32;
    localparam logic [31:0] DEF_PC_RST = 32'h1C00_0000;
    localparam logic [31:0] INST_NOP   = 32'h0340_0000;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } mode_t;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen front-end bus: fetch request, in-order memory response,
// and the IF/ID delivery handshake.
interface pc_gen_if #(
    parameter int WORD = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [WORD-1:0] req_pc;
    logic            resp_valid;
    logic [31:0]     resp_inst;
    logic            if_valid;
    logic            if_ready;
    logic [WORD-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            if_adef;

    modport master (
        output req_valid, req_pc,
        input  req_ready,
        input  resp_valid, resp_inst,
        output if_valid, if_pc, if_inst, if_adef,
        input  if_ready
    );

    modport slave (
        input  req_valid, req_pc,
        output req_ready,
        output resp_valid, resp_inst,
        input  if_valid, if_pc, if_inst, if_adef,
        output if_ready
    );

endinterface

// File: rtl/pc_gen_fifo.sv
// pc_fifo: synchronous FIFO with single-cycle flush and occupancy count.
// Used both for fetched entries and for the shadow PC queue.
module pc_fifo
    import pc_gen_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: PC owner, redirect arbiter and credit-limited fetch issuer.
// Optional PC_ALIGN_CHECK_EN traps misaligned redirect targets.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              WORD   = DEF_WORD,
    parameter logic [WORD-1:0] PC_RST = WORD'(DEF_PC_RST),
    parameter int              DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            exc_valid,
    input  logic [WORD-1:0] exc_target,
    input  logic            br_taken,
    input  logic [WORD-1:0] br_target,
    pc_gen_if.master        bus,
    output logic [WORD-1:0] pc_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = AW + 3;
    localparam int EW = WORD + 33;

    logic [WORD-1:0] pc_q;
    logic [WORD-1:0] target;
    logic [WORD-1:0] tgt_load;
    logic [WORD-1:0] sh_head;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   sh_cnt_unused;
    logic [DW-1:0]   drop_cnt;
    logic [EW-1:0]   fifo_din;
    logic [EW-1:0]   fifo_dout;
    logic [CW:0]     credit;
    logic            redirect;
    logic            frozen;
    logic            nop_push;
    logic            fire_req;
    logic            resp_live;
    logic            resp_drop;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic            sh_full_unused;
    logic            sh_empty_unused;

    assign redirect  = exc_valid | br_taken;
    assign target    = exc_valid ? exc_target : br_target;
    assign credit    = {1'b0, inflight} + {1'b0, fifo_cnt};

    assign bus.req_valid = !rst && !stall && !redirect && !frozen
                         && (credit < (CW+1)'(DEPTH));
    assign bus.req_pc    = pc_q;
    assign pc_out        = pc_q;

    assign fire_req  = bus.req_valid && bus.req_ready;
    assign resp_live = bus.resp_valid && (drop_cnt == '0) && !redirect;
    assign resp_drop = bus.resp_valid && (drop_cnt != '0) && !redirect;
    assign pop       = !fifo_empty && bus.if_ready && !redirect;

    assign fifo_din = nop_push ? {pc_q, INST_NOP, 1'b1}
                               : {sh_head, bus.resp_inst, 1'b0};

    // Program counter: redirect wins over sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pc_q <= PC_RST;
        else if (redirect) pc_q <= tgt_load;
        else if (fire_req) pc_q <= pc_q + WORD'(PC_STEP);
    end

    // Live requests in flight; on redirect they all become stale drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            inflight <= '0;
            drop_cnt <= drop_cnt + DW'(inflight) - DW'(bus.resp_valid);
        end else begin
            unique case ({fire_req, resp_live})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            if (resp_drop) drop_cnt <= drop_cnt - DW'(1);
        end
    end

    pc_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_live || nop_push),
        .pop   (pop),
        .flush (redirect),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .full  (fifo_full_unused),
        .empty (fifo_empty)
    );

    pc_fifo #(.W(WORD), .DEPTH(DEPTH)) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .push  (fire_req),
        .pop   (resp_live),
        .flush (redirect),
        .din   (pc_q),
        .dout  (sh_head),
        .count (sh_cnt_unused),
        .full  (sh_full_unused),
        .empty (sh_empty_unused)
    );

    assign bus.if_valid = !fifo_empty;
    assign bus.if_pc    = fifo_empty ? '0 : fifo_dout[EW-1 -: WORD];
    assign bus.if_inst  = fifo_empty ? '0 : fifo_dout[32:1];

`ifdef PC_ALIGN_CHECK_EN
    mode_t state;
    mode_t state_nxt;
    logic  misaligned;
    logic  nop_pend;

    assign misaligned = (target[1:0] != 2'b00);
    assign tgt_load   = target;
    assign nop_push   = frozen && nop_pend && (drop_cnt == '0)
                      && (inflight == '0) && !redirect;
    assign bus.if_adef = fifo_empty ? 1'b0 : fifo_dout[0];

    // Mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Mode transitions: only a redirect changes mode
    always_comb begin
        state_nxt = state;
        if (redirect) state_nxt = misaligned ? FROZEN : RUN;
    end

    // Mode decode
    always_comb begin
        frozen = (state == FROZEN);
    end

    // One NOP/adef entry per misaligned redirect, after stale drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           nop_pend <= 1'b0;
        else if (redirect) nop_pend <= misaligned;
        else if (nop_push) nop_pend <= 1'b0;
    end
`else
    logic       adef_unused;
    logic [1:0] lowbits_unused;

    assign adef_unused    = fifo_dout[0];
    assign lowbits_unused = target[1:0];
    assign tgt_load       = {target[WORD-1:2], 2'b00};
    assign frozen         = 1'b0;
    assign nop_push       = 1'b0;
    assign bus.if_adef    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: random and directed stimulus against a queue-based
// model of the fetch stream (outstanding requests + visible entries).
module tb_pc_gen;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RST   = 32'h1C00_0000;
    localparam logic [31:0] NOP      = 32'h0340_0000;

    typedef struct {
        logic [31:0] pc;
        bit          live;
        int          rdy;
    } outst_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          adef;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_out;

    pc_gen_if #(.WORD(32)) bus ();

    pc_gen #(.WORD(32), .PC_RST(PC_RST), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .exc_valid  (exc_valid),
        .exc_target (exc_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .bus        (bus),
        .pc_out     (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outst_t      oq[$];
    ent_t        eq[$];
    ent_t        popped[$];
    logic [31:0] m_pc;
    bit          m_frozen;
    bit          m_nop;
    int          cyc;
    int          n_vec;
    int          n_err;
    int          n_acc;

    bit          d_stall, d_exc, d_br, d_ifr, d_rqr;
    logic [31:0] d_ext, d_brt;
    int          d_lat;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_inst(input logic [31:0] pc);
        logic [31:0] k;
        k = 32'h9E37_79B1;
        return (pc * k) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] low;
        base = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
             : 32'h1C00_0000 + (32'($urandom_range(0, 255)) << 4);
        off  = 32'($urandom_range(0, 3)) << 2;
        low  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
        return base + off + low;
    endfunction

    task automatic set_d(input bit s, input bit ifr, input bit rqr, input int lat);
        d_stall = s;
        d_ifr   = ifr;
        d_rqr   = rqr;
        d_lat   = lat;
        d_exc   = 1'b0;
        d_br    = 1'b0;
    endtask

    task automatic cycle(input bit rnd);
        bit          redir, exp_rv, rv_in, nopnow;
        int          live, lat;
        logic [31:0] tgt;
        outst_t      o;
        if (rnd) begin
            stall         = ($urandom_range(0, 3) == 0);
            exc_valid     = ($urandom_range(0, 39) == 0);
            br_taken      = ($urandom_range(0, 19) == 0);
            exc_target    = rnd_tgt();
            br_target     = rnd_tgt();
            bus.if_ready  = ($urandom_range(0, 3) != 0);
            bus.req_ready = ($urandom_range(0, 3) != 0);
            lat           = $urandom_range(1, 4);
        end else begin
            stall         = d_stall;
            exc_valid     = d_exc;
            br_taken      = d_br;
            exc_target    = d_ext;
            br_target     = d_brt;
            bus.if_ready  = d_ifr;
            bus.req_ready = d_rqr;
            lat           = d_lat;
        end
        rv_in = (oq.size() > 0) && (oq[0].rdy <= cyc)
              && (!rnd || $urandom_range(0, 3) != 0);
        bus.resp_valid = rv_in;
        bus.resp_inst  = rv_in ? f_inst(oq[0].pc) : 32'($urandom);
        #1;
        redir = exc_valid || br_taken;
        live  = 0;
        foreach (oq[i]) if (oq[i].live) live++;
        exp_rv = !stall && !redir && !m_frozen && ((live + eq.size()) < DEPTH);
        chk("req_valid", 32'(bus.req_valid), 32'(exp_rv));
        chk("pc_out", pc_out, m_pc);
        chk("req_pc", bus.req_pc, m_pc);
        chk("if_valid", 32'(bus.if_valid), 32'(eq.size() != 0));
        if (eq.size() != 0) begin
            chk("if_pc", bus.if_pc, eq[0].pc);
            chk("if_inst", bus.if_inst, eq[0].inst);
            chk("if_adef", 32'(bus.if_adef), 32'(eq[0].adef));
        end
        if (bus.req_valid && bus.req_ready) n_acc++;
        if (!redir && bus.if_valid && bus.if_ready)
            popped.push_back('{bus.if_pc, bus.if_inst, bus.if_adef});
        if (redir) begin
            if (rv_in) void'(oq.pop_front());
            foreach (oq[i]) oq[i].live = 1'b0;
            eq.delete();
            tgt = exc_valid ? exc_target : br_target;
`ifdef PC_ALIGN_CHECK_EN
            m_pc     = tgt;
            m_frozen = (tgt[1:0] != 2'b00);
            m_nop    = m_frozen;
`else
            m_pc = tgt & 32'hFFFF_FFFC;
`endif
        end else begin
            nopnow = m_frozen && m_nop && (oq.size() == 0);
            if (bus.if_ready && eq.size() != 0) void'(eq.pop_front());
            if (rv_in) begin
                o = oq.pop_front();
                if (o.live) eq.push_back('{o.pc, f_inst(o.pc), 1'b0});
            end
            if (nopnow) begin
                eq.push_back('{m_pc, NOP, 1'b1});
                m_nop = 1'b0;
            end
            if (exp_rv && bus.req_ready) begin
                oq.push_back('{m_pc, 1'b1, cyc + lat});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        stall          = 1'b0;
        exc_valid      = 1'b0;
        br_taken       = 1'b0;
        bus.if_ready   = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_pc", pc_out, PC_RST);
        chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        chk("rst_if_adef", 32'(bus.if_adef), 32'd0);
        oq.delete();
        eq.delete();
        m_pc     = PC_RST;
        m_frozen = 1'b0;
        m_nop    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        exc_valid      = 1'b0;
        br_taken       = 1'b0;
        exc_target     = '0;
        br_target      = '0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_inst  = '0;
        bus.if_ready   = 1'b0;
        d_ext = '0;
        d_brt = '0;
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        n_acc = 0;
        @(negedge clk);
        do_reset();
        chk("post_rst_req_pc", bus.req_pc, 32'h1C00_0000);

        // back-to-back stream, latency 1
        set_d(0, 1, 1, 1);
        popped.delete();
        repeat (7) cycle(0);
        chk("b2b_cnt", 32'(popped.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("b2b_pc", popped[i].pc, PC_RST + 32'(4 * i));
            chk("b2b_inst", popped[i].inst, f_inst(PC_RST + 32'(4 * i)));
        end

        // credit limit with consumer blocked
        do_reset();
        set_d(0, 0, 1, 1);
        n_acc = 0;
        repeat (8) cycle(0);
        chk("credit_acc", 32'(n_acc), 32'(DEPTH));
        chk("credit_block", 32'(bus.req_valid), 32'd0);
        d_ifr = 1'b1;
        cycle(0);
        d_ifr = 1'b0;
        n_acc = 0;
        cycle(0);
        chk("credit_reopen", 32'(n_acc), 32'd1);
        cycle(0);
        chk("credit_reblock", 32'(n_acc), 32'd1);

        // branch with two requests in flight
        do_reset();
        set_d(0, 1, 1, 3);
        repeat (2) cycle(0);
        popped.delete();
        d_br  = 1'b1;
        d_brt = 32'h1C00_0100;
        cycle(0);
        d_br = 1'b0;
        repeat (12) cycle(0);
        chk("br_cnt", 32'(popped.size() >= 2), 32'd1);
        chk("br_first_pc", popped[0].pc, 32'h1C00_0100);
        chk("br_second_pc", popped[1].pc, 32'h1C00_0104);

        // exception beats branch in the same cycle
        d_exc = 1'b1;
        d_ext = 32'h1C00_8000;
        d_br  = 1'b1;
        d_brt = 32'h1C00_4000;
        cycle(0);
        d_exc = 1'b0;
        d_br  = 1'b0;
        chk("exc_prio", pc_out, 32'h1C00_8000);
        repeat (4) cycle(0);

        // misaligned redirect target
        d_br  = 1'b1;
        d_brt = 32'h1C00_0102;
        cycle(0);
        d_br = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        popped.delete();
        n_acc = 0;
        repeat (10) cycle(0);
        chk("frz_acc", 32'(n_acc), 32'd0);
        chk("frz_cnt", 32'(popped.size()), 32'd1);
        chk("frz_pc", popped[0].pc, 32'h1C00_0102);
        chk("frz_inst", popped[0].inst, NOP);
        chk("frz_adef", 32'(popped[0].adef), 32'd1);
        d_br  = 1'b1;
        d_brt = 32'h1C00_0200;
        cycle(0);
        d_br  = 1'b0;
        n_acc = 0;
        repeat (4) cycle(0);
        chk("frz_resume", 32'(n_acc > 0), 32'd1);
`else
        chk("align_force", pc_out, 32'h1C00_0100);
        repeat (4) cycle(0);
`endif

        // random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                chk("mid_rst_req_pc", bus.req_pc, 32'h1C00_0000);
            end
            cycle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator that supersedes the bare PC register in the front end. It owns the program counter, arbitrates exception and branch redirects, and issues credit-limited fetch requests to instruction memory. It buffers in-order responses and delivers {pc, inst} pairs to the IF/ID stage under a valid/ready handshake, discarding responses that were made stale by a redirect.

## Interface
Parameters:
- WORD, 32, address/data width
- PC_RST, 32'h1C00_0000, reset PC
- DEPTH, 4, max requests in flight plus buffered entries (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard hold; blocks new requests only
- exc_valid  in  1  exception/ertn redirect, highest priority
- exc_target  in  WORD  exception redirect address
- br_taken  in  1  branch/jump redirect from EX
- br_target  in  WORD  branch redirect address
- req_valid  out  1  fetch request valid
- req_ready  in  1  I-mem accepts request
- req_pc  out  WORD  fetch address, equal to pc_out
- resp_valid  in  1  I-mem response, in order, no backpressure, ≥1 cycle after acceptance
- resp_inst  in  32  fetched instruction
- if_valid  out  1  IF/ID entry valid
- if_ready  in  1  IF/ID consumes entry
- if_pc  out  WORD  PC of entry
- if_inst  out  32  instruction of entry
- if_adef  out  1  address-error flag of entry
- pc_out  out  WORD  current PC register

## Operation
- Reset values: pc_out=PC_RST, req_valid=0, if_valid=0, if_pc=0, if_inst=0, if_adef=0, inflight=0, drop_cnt=0, FIFO empty.
- credit = inflight + fifo_count. req_valid = !stall && !redirect && !frozen && credit<DEPTH.
- Request handshake (req_valid && req_ready): pc <= pc+4 (modulo 2^WORD), inflight++.
- Response: if drop_cnt>0 then discard and decrement drop_cnt; otherwise push {pc of oldest inflight, resp_inst, 0}, inflight--. The oldest PC is held in a shadow queue of depth DEPTH.
- Redirect = exc_valid | br_taken; target = exc_valid ? exc_target : br_target. Next cycle:
  - pc=target
  - FIFO flushed
  - drop_cnt = inflight, including any response arriving in the redirect cycle, which is also discarded
  - inflight=0
  - frozen cleared
- Simultaneous redirect and if_ready: the head is not popped and is discarded by the flush.
- Output: if_valid = FIFO non-empty; pop on if_valid && if_ready. stall does not affect the output side.
- No state machine beyond a two-state mode: RUN and FROZEN (FROZEN exists only with the macro below).

## Timing
- req_pc/req_valid are combinational from registers and inputs (stall, redirect).
- Response to if_valid: 1 cycle (FIFO write, visible the next cycle); no bypass.
- Redirect in cycle N: req_valid=0 in N; the first request to the target is in N+1.
- Steady-state throughput is one instruction per cycle when DEPTH ≥ memory latency+1.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Redirect target with [1:0]≠0 loads pc unchanged and enters FROZEN.
  - FROZEN issues no requests; once drop_cnt=0 and inflight=0, it pushes one entry {target, 32'h0340_0000 (NOP), adef=1}.
  - FROZEN stays until the next redirect.
- Undefined: target[1:0] is forced to 0 on load, and if_adef is tied 0.

## Structure
- Shared package/header: WORD, PC_RST, INST_NOP, PC_STEP (4).
- Sub-module pc_fifo: synchronous FIFO, width WORD+33, depth DEPTH, with flush, count, full and empty outputs. Reused for the shadow PC queue with width WORD.

## Test plan
- Reset mid-run, asserted asynchronously: pc_out=32'h1C00_0000 immediately, if_valid=0; after release, the first req_pc=32'h1C00_0000.
- Memory latency 1, if_ready=1, 5 requests: if_pc = 1C00_0000…1C00_0010 back-to-back, inst matches.
- if_ready=0, DEPTH=4: exactly 4 requests accepted, then req_valid=0; one pop re-enables one request.
- br_taken with target 0x1C00_0100 while 2 requests are in flight: both responses dropped; next if_pc=0x1C00_0100.
- exc_valid and br_taken in the same cycle (exc_target 0x1C00_8000): pc=0x1C00_8000.
- With PC_ALIGN_CHECK_EN, br_target 0x1C00_0102: no requests; one entry with if_adef=1, if_inst=0340_0000; a following redirect to 0x1C00_0200 resumes fetch.
